// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
// Default widths match the 16 x 16-bit register file used by the core.
package rf_pkg;

    localparam int REG_ID_W = 4;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;

    typedef logic [REG_ID_W-1:0] reg_id_t;
    typedef logic [DATA_W-1:0]   rf_data_t;

    typedef struct packed {
        reg_id_t  regId;
        rf_data_t data;
    } wb_req_t;

    // A single requester still needs a one-bit index.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or above the pointer,
// wrapping around, and moves the pointer just past each winner.
module rr_arbiter
    import rf_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idxWidth(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grantIdx
);

    logic [IW-1:0] ptr;
    logic          found;
    int            cand;

    always_comb begin
        grant    = '0;
        grantIdx = '0;
        found    = 1'b0;
        cand     = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (enable && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grantIdx    = IW'(cand);
            end
        end
    end

    // The pointer only moves on an actual grant, so an idle or held port
    // keeps its fairness position.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (found) begin
            if (int'(grantIdx) == N - 1) begin
                ptr <= '0;
            end else begin
                ptr <= grantIdx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between N_REQ writeback requesters and
// tracks outstanding writes per register. Define RF_ZERO_REG_EN to make r0 read-only zero.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int DATA_W   = 16,
    parameter int REG_ID_W = 4,
    parameter int NUM_REGS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*REG_ID_W-1:0] req_reg,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic                      hold,
    input  logic                      rsv_valid,
    input  logic [REG_ID_W-1:0]       rsv_reg,
    output logic                      rf_wen,
    output logic [REG_ID_W-1:0]       rf_dst_reg,
    output logic [DATA_W-1:0]         rf_dst_data,
    output logic [NUM_REGS-1:0]       busy
);

    localparam int IDX_W = idxWidth(N_REQ);

    logic [N_REQ-1:0]    grant;
    logic [IDX_W-1:0]    grantIdx;
    logic                anyGrant;
    logic [REG_ID_W-1:0] winReg;
    logic [DATA_W-1:0]   winData;
    logic                winWrites;
    logic                rsvAccept;
    logic                arbEnable;
    logic [NUM_REGS-1:0] busyNext;

    assign arbEnable = ~hold;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IDX_W)
    ) uArbiter (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .enable   (arbEnable),
        .grant    (grant),
        .grantIdx (grantIdx)
    );

    assign req_ready = grant;
    assign anyGrant  = |grant;
    assign winReg    = req_reg[int'(grantIdx)*REG_ID_W +: REG_ID_W];
    assign winData   = req_data[int'(grantIdx)*DATA_W +: DATA_W];

`ifdef RF_ZERO_REG_EN
    // r0 writes still consume a handshake but never reach the register file.
    assign winWrites = (winReg != '0);
    assign rsvAccept = rsv_valid && (rsv_reg != '0);
`else
    assign winWrites = 1'b1;
    assign rsvAccept = rsv_valid;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wen      <= 1'b0;
            rf_dst_reg  <= '0;
            rf_dst_data <= '0;
        end else if (anyGrant) begin
            rf_wen      <= winWrites;
            rf_dst_reg  <= winReg;
            rf_dst_data <= winData;
        end else begin
            rf_wen      <= 1'b0;
        end
    end

    // Clear first, then set, so a reservation landing on the retiring edge wins.
    always_comb begin
        busyNext = busy;
        if (rf_wen) begin
            busyNext[rf_dst_reg] = 1'b0;
        end
        if (rsvAccept) begin
            busyNext[rsv_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busyNext;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a high-level model (round-robin scan,
// scoreboard bits, register-file array) checked every cycle, plus directed scenarios.
module tb_regfile_wb_arbiter;
    import rf_pkg::*;

`ifdef RF_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_reg;
    logic [31:0] req_data;
    logic        hold;
    logic        rsv_valid;
    logic [3:0]  rsv_reg;
    logic        rf_wen;
    logic [3:0]  rf_dst_reg;
    logic [15:0] rf_dst_data;
    logic [15:0] busy;

    regfile_wb_arbiter #(
        .N_REQ    (2),
        .DATA_W   (16),
        .REG_ID_W (4),
        .NUM_REGS (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_reg     (req_reg),
        .req_data    (req_data),
        .hold        (hold),
        .rsv_valid   (rsv_valid),
        .rsv_reg     (rsv_reg),
        .rf_wen      (rf_wen),
        .rf_dst_reg  (rf_dst_reg),
        .rf_dst_data (rf_dst_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          mPtr;
    bit          mWen;
    int          mReg;
    logic [15:0] mData;
    logic [15:0] mBusy;
    logic [15:0] rfMem [16];
    bit          rfWr [16];
    logic [15:0] dutMem [16];
    bit          dutWr [16];
    int          lastGrant;

    function automatic wb_req_t mk(input int r, input int d);
        wb_req_t t;
        t.regId = 4'(r);
        t.data  = 16'(d);
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic doReset();
        rst       = 1'b0;
        req_valid = '0;
        hold      = 1'b0;
        rsv_valid = 1'b0;
        rsv_reg   = '0;
        #2;
        mPtr  = 0;
        mWen  = 1'b0;
        mReg  = 0;
        mData = '0;
        mBusy = '0;
        checkOutput("reset_wen",  32'(rf_wen), 0);
        checkOutput("reset_reg",  32'(rf_dst_reg), 0);
        checkOutput("reset_data", 32'(rf_dst_data), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        rst = 1'b1;
    endtask

    // One clock cycle: drive inputs, check the grant, advance the model, check the outputs.
    task automatic applyStimulus(input logic [1:0] v, input wb_req_t r0, input wb_req_t r1,
                                 input bit hd, input bit rv, input int rr);
        wb_req_t     reqs [2];
        int          w;
        logic [1:0]  expReady;
        bit          nWen;
        int          nReg;
        logic [15:0] nData;
        logic [15:0] nBusy;
        bit          dWen;
        int          dReg;
        logic [15:0] dData;

        reqs[0]   = r0;
        reqs[1]   = r1;
        req_valid = v;
        req_reg   = {r1.regId, r0.regId};
        req_data  = {r1.data, r0.data};
        hold      = hd;
        rsv_valid = rv;
        rsv_reg   = 4'(rr);
        #1;

        w = -1;
        if (!hd) begin
            for (int k = 0; k < 2; k++) begin
                if (w < 0 && v[(mPtr + k) % 2]) w = (mPtr + k) % 2;
            end
        end
        expReady = (w >= 0) ? 2'(1 << w) : 2'b00;
        checkOutput("req_ready", 32'(req_ready), 32'(expReady));
        lastGrant = w;

        nReg  = mReg;
        nData = mData;
        nWen  = 1'b0;
        if (w >= 0) begin
            nReg  = int'(reqs[w].regId);
            nData = reqs[w].data;
            nWen  = !(ZERO_EN && nReg == 0);
            mPtr  = (w + 1) % 2;
        end
        nBusy = mBusy;
        if (mWen) nBusy[mReg] = 1'b0;
        if (rv && !(ZERO_EN && rr == 0)) nBusy[rr] = 1'b1;

        dWen  = rf_wen;
        dReg  = int'(rf_dst_reg);
        dData = rf_dst_data;

        @(posedge clk);
        #1;
        if (dWen) begin
            dutMem[dReg] = dData;
            dutWr[dReg]  = 1'b1;
        end
        if (mWen) begin
            rfMem[mReg] = mData;
            rfWr[mReg]  = 1'b1;
        end
        mWen  = nWen;
        mReg  = nReg;
        mData = nData;
        mBusy = nBusy;

        checkOutput("rf_wen", 32'(rf_wen), 32'(mWen));
        if (mWen) begin
            checkOutput("rf_dst_reg",  32'(rf_dst_reg), 32'(mReg));
            checkOutput("rf_dst_data", 32'(rf_dst_data), 32'(mData));
        end
        checkOutput("busy", 32'(busy), 32'(mBusy));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(2'b00, mk(0, 0), mk(0, 0), 1'b0, 1'b0, 0);
    endtask

    wb_req_t     agentReq [2];
    bit          agentV [2];

    initial begin
        for (int r = 0; r < 16; r++) begin
            rfMem[r] = '0; rfWr[r] = 1'b0; dutMem[r] = '0; dutWr[r] = 1'b0;
        end
        req_reg  = '0;
        req_data = '0;
        doReset();

        // Reset between handshake and retirement drops the write.
        applyStimulus(2'b01, mk(3, 16'h1234), mk(0, 0), 1'b0, 1'b0, 0);
        checkOutput("rstmid_wen_before", 32'(rf_wen), 1);
        doReset();
        idle(2);
        checkOutput("rstmid_reg3_written", 32'(dutWr[3]), 0);

        // Continuous contention alternates winners.
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'b11, mk(1, 16'hAAAA), mk(2, 16'h5555), 1'b0, 1'b0, 0);
            checkOutput("contend_grant", 32'(lastGrant), 32'(k % 2));
            checkOutput("contend_wen", 32'(rf_wen), 1);
        end

        // Hold blocks new grants; the pointer resumes where it was.
        doReset();
        applyStimulus(2'b11, mk(1, 16'h0101), mk(2, 16'h0202), 1'b0, 1'b0, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b11, mk(1, 16'h0101), mk(2, 16'h0202), 1'b1, 1'b0, 0);
            checkOutput("hold_wen", 32'(rf_wen), 0);
        end
        applyStimulus(2'b11, mk(1, 16'h0101), mk(2, 16'h0202), 1'b0, 1'b0, 0);
        checkOutput("hold_release_grant", 32'(lastGrant), 1);
        idle(1);

        // Reservation on the retiring edge wins over the clear.
        doReset();
        applyStimulus(2'b00, mk(0, 0), mk(0, 0), 1'b0, 1'b1, 5);
        checkOutput("sb_set", 32'(busy[5]), 1);
        applyStimulus(2'b01, mk(5, 16'hBEEF), mk(0, 0), 1'b0, 1'b0, 0);
        applyStimulus(2'b00, mk(0, 0), mk(0, 0), 1'b0, 1'b1, 5);
        checkOutput("sb_race_keep", 32'(busy[5]), 1);
        applyStimulus(2'b01, mk(5, 16'hC0DE), mk(0, 0), 1'b0, 1'b0, 0);
        applyStimulus(2'b00, mk(0, 0), mk(0, 0), 1'b0, 1'b0, 0);
        checkOutput("sb_clear", 32'(busy[5]), 0);

        // Same destination from both requesters: later grant wins.
        doReset();
        applyStimulus(2'b11, mk(7, 16'h0001), mk(7, 16'h0002), 1'b0, 1'b0, 0);
        applyStimulus(2'b10, mk(7, 16'h0001), mk(7, 16'h0002), 1'b0, 1'b0, 0);
        checkOutput("conflict_second_grant", 32'(lastGrant), 1);
        idle(2);
        checkOutput("conflict_reg7", 32'(dutMem[7]), 16'h0002);

        // Register 0 behaviour depends on RF_ZERO_REG_EN.
        doReset();
        applyStimulus(2'b01, mk(0, 16'hFFFF), mk(0, 0), 1'b0, 1'b1, 0);
        checkOutput("zero_grant", 32'(lastGrant), 0);
        checkOutput("zero_wen", 32'(rf_wen), ZERO_EN ? 0 : 1);
        checkOutput("zero_busy0", 32'(busy[0]), ZERO_EN ? 0 : 1);
        idle(2);

        // Randomized traffic with stable-until-handshake requesters.
        doReset();
        agentV[0] = 1'b0;
        agentV[1] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                doReset();
                agentV[0] = 1'b0;
                agentV[1] = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                if (!agentV[i] && ($urandom % 3) != 0) begin
                    agentV[i]   = 1'b1;
                    agentReq[i] = mk(int'($urandom_range(0, 15)), int'($urandom % 65536));
                end
            end
            applyStimulus({agentV[1], agentV[0]}, agentReq[0], agentReq[1],
                          ($urandom % 5) == 0, ($urandom % 3) == 0, int'($urandom_range(0, 15)));
            if (lastGrant >= 0) agentV[lastGrant] = 1'b0;
        end
        idle(2);

        for (int r = 0; r < 16; r++) begin
            checkOutput("rf_mem_written", 32'(dutWr[r]), 32'(rfWr[r]));
            checkOutput("rf_mem_value", 32'(dutMem[r]), 32'(rfMem[r]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (write enable, destination id, write data) between N_REQ writeback requesters, e.g. ALU writeback, load writeback and a debug/init port.
- Round-robin arbitration with valid/ready handshakes; the winning write is registered before it reaches the register file.
- Keeps a per-register pending scoreboard (set on reservation, cleared on retirement) that the decode stage uses for stall decisions.

Parameters:
- N_REQ, 2, number of writeback requesters (2..4).
- DATA_W, 16, register data width.
- REG_ID_W, 4, register id width.
- NUM_REGS, 16, register count; must equal 2**REG_ID_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester write request.
- req_ready  out  N_REQ  per-requester grant; a handshake completes when valid and ready are both high.
- req_reg  in  N_REQ*REG_ID_W  flattened destination ids; requester i occupies bits [i*REG_ID_W +: REG_ID_W].
- req_data  in  N_REQ*DATA_W  flattened write data; requester i occupies bits [i*DATA_W +: DATA_W].
- hold  in  1  stalls the write port; no grants while high.
- rsv_valid  in  1  reserve a destination register (issue stage).
- rsv_reg  in  REG_ID_W  register to reserve.
- rf_wen  out  1  register file write enable.
- rf_dst_reg  out  REG_ID_W  register file destination id.
- rf_dst_data  out  DATA_W  register file write data.
- busy  out  NUM_REGS  scoreboard; bit r high means a write to r is outstanding.

Behaviour:
- Reset (rst low, asynchronous): rf_wen=0, rf_dst_reg=0, rf_dst_data=0, busy=0, rr pointer=0. Any registered write not yet retired is dropped.
- Grant logic:
  - Combinational from req_valid, the rr pointer and hold.
  - Exactly one req_ready is high when hold=0 and any valid is high.
  - The winner is the first valid index at or above the pointer, wrapping modulo N_REQ.
  - req_ready is all zeros when hold=1 or no valid is high.
  - req_ready may depend on req_valid; requesters must not make valid depend on ready.
- Requester rule: once valid is high, reg, data and valid stay stable until the handshake completes.
- Pointer: after a grant to index w, pointer <= (w+1) mod N_REQ. The pointer is unchanged when there is no grant.
- Output stage:
  - On a grant edge: rf_wen<=1, rf_dst_reg/rf_dst_data <= winner's reg/data.
  - With no grant: rf_wen<=0 and rf_dst_reg/rf_dst_data hold their values.
  - Latency is handshake cycle +1 to rf_wen, with the register file capturing on the next edge. Throughput is one write per cycle.
- Scoreboard:
  - Set: busy[r] <= 1 on any edge with rsv_valid=1 and rsv_reg=r.
  - Clear: busy[r] <= 0 on any edge with rf_wen=1 and rf_dst_reg=r (the retiring edge).
  - Same register set and cleared on the same edge: set wins (the new reservation stays outstanding).
  - Reserving an already busy register keeps the bit at 1; there is no count.
  - Writes to non-reserved registers are legal and leave busy unchanged.
- Same-register requests from two requesters in one cycle are serialized in rr order with no merging, so the later-granted data ends up in the register.
- hold rising while a write is registered: the registered write still retires; only new grants are blocked.

Optional Feature:
- Macro: RF_ZERO_REG_EN.
- Defined:
  - Register 0 is read-only zero.
  - Requests to reg 0 still handshake and advance the pointer, but the output stage loads rf_wen=0.
  - Reservations of reg 0 are ignored, so busy[0] is constantly 0.
- Undefined: register 0 is treated like every other register.

Decomposition:
- Package rf_pkg:
  - Constants REG_ID_W=4, DATA_W=16, NUM_REGS=16.
  - Typedefs reg_id_t (logic [REG_ID_W-1:0]) and rf_data_t (logic [DATA_W-1:0]).
  - A wb_req_t struct holding reg and data.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req vector, enable, clk, rst.
  - Outputs: one-hot grant and binary grant index.
  - Owns the rr pointer.
- The top level holds the output register and the scoreboard.

Test Plan:
1. Reset mid-write: req0 valid reg 3 data 0x1234, handshake, assert rst low before the retiring edge -> rf_wen=0, busy=0, and register 3 is not written.
2. Contention: both requesters valid continuously, req0 reg1 0xAAAA, req1 reg2 0x5555, pointer 0 -> grants alternate 0,1,0,1, and rf_wen stays high each cycle from cycle 2.
3. Hold: hold=1 for 3 cycles with both requesters valid -> req_ready=00 and rf_wen=0 from the cycle after hold rises; after release, the first grant goes to the pointer index.
4. Scoreboard race: rsv reg 5, then a write to reg 5 retires on the same edge as a new rsv reg 5 -> busy[5] stays 1; a further retire with no rsv -> busy[5]=0.
5. Same-register conflict: both requesters write reg 7, req0 0x0001 and req1 0x0002, pointer 0 -> two retirements, and the final register 7 value is 0x0002.
6. RF_ZERO_REG_EN defined: req0 writes reg 0 data 0xFFFF and rsv reg 0 -> handshake completes, rf_wen=0, busy[0]=0; undefined -> rf_wen=1 and busy[0] set.
